dma_isr_arbiter: RTL and testbench
==================================

DMA_ISR_ARBITER -- requirements
Module: dma_isr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- N_ID, default 4, number of requesters (2..16)
- REQ_BITS, default 128, width of one ISR DMA request descriptor
- N_OUTSTANDING, default 8, maximum issued-but-not-completed requests (power of 2)
REQ-002 Ports SHALL be, one per line:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- s_req_valid  in  N_ID  per-requester request valid
- s_req_ready  out  N_ID  per-requester request accept
- s_req_data  in  N_ID*REQ_BITS  per-requester descriptor; slice i = bits [i*REQ_BITS +: REQ_BITS]
- m_req_valid  out  1  shared-channel request valid
- m_req_ready  in  1  shared-channel accept
- m_req_data  out  REQ_BITS  granted descriptor
- m_done  in  1  one-cycle completion pulse from the shared channel, in issue order
- s_done  out  N_ID  one-hot completion pulse to the owning requester
- err_spurious  out  1  sticky flag: m_done received with nothing outstanding
- outstanding  out  clog2(N_OUTSTANDING)+1  current outstanding count

Function
REQ-003 The arbiter SHALL grant round-robin: the search starts at last_grant+1 mod N_ID, and last_grant resets to N_ID-1, so requester 0 has first priority.
REQ-004 The FSM SHALL have two states, IDLE and ISSUE.
REQ-005 In IDLE with any s_req_valid set and outstanding < N_OUTSTANDING, the arbiter SHALL assert s_req_ready for the winner only, for exactly that cycle, capture its descriptor into m_req_data, and move to ISSUE.
REQ-006 In ISSUE, m_req_valid SHALL be 1 and m_req_data SHALL be held stable until m_req_ready=1; on that handshake the arbiter SHALL return to IDLE.
REQ-007 The minimum latency from s_req_valid to m_req_valid SHALL be 1 cycle; issue throughput SHALL be at most one request every 2 cycles.
REQ-008 On each m_req handshake, the winner ID SHALL be pushed into an ID FIFO of depth N_OUTSTANDING, and outstanding SHALL increment.
REQ-009 On m_done with outstanding > 0, the head ID SHALL be popped, s_done[head] SHALL pulse on the next cycle, and outstanding SHALL decrement.
REQ-010 A push and a pop in the same cycle SHALL leave outstanding unchanged and preserve FIFO order.
REQ-011 When outstanding = N_OUTSTANDING, no grant SHALL occur; s_req_ready SHALL stay 0 until a pop frees a slot.
REQ-012 The full condition SHALL be evaluated with the pop of the current cycle excluded, i.e. no same-cycle bypass.
REQ-013 m_done with outstanding = 0 SHALL be ignored: no pop, no s_done, and err_spurious set to 1 until reset.
REQ-014 A requester deasserting s_req_valid before it is granted SHALL cause no grant and no state change for that requester.
REQ-015 FIFO pointers SHALL wrap modulo N_OUTSTANDING.

Reset
REQ-016 While areset=1 at a rising aclk edge, the block SHALL reset to:
- state IDLE
- last_grant = N_ID-1
- FIFO empty; outstanding = 0
- s_req_ready = 0, m_req_valid = 0, m_req_data = 0
- s_done = 0, err_spurious = 0
REQ-017 Reset asserted mid-ISSUE SHALL drop the pending request and all outstanding IDs; m_done pulses arriving after reset are treated as spurious.

Configuration
REQ-018 With macro DMA_ISR_ARB_STATS_EN defined, the block SHALL add output grant_cnt (N_ID*32 bits): one 32-bit wrapping counter per requester, incremented on that requester's s_req handshake and cleared by areset.
REQ-019 Without DMA_ISR_ARB_STATS_EN, the grant_cnt port and its logic SHALL be absent, with no other behavioural change.

Verification
REQ-020 Scenario: requesters 0..3 all valid, m_req_ready=1 -> grant order 0,1,2,3,0; one m_req handshake every 2 cycles; first m_req_valid 1 cycle after reset release plus 1.
REQ-021 Scenario: requester 2 alone valid, m_req_ready held 0 for 5 cycles -> m_req_valid high 5+ cycles with m_req_data constant; s_req_ready[2] pulses exactly once.
REQ-022 Scenario: 8 requests issued, no m_done -> outstanding=8 and s_req_ready=0; one m_done -> s_done pulses for the first-issued ID 1 cycle later, then a new grant occurs.
REQ-023 Scenario: m_done coincides with an m_req handshake at outstanding=3 -> outstanding remains 3 and the s_done ID matches the FIFO head.
REQ-024 Scenario: m_done with outstanding=0 -> err_spurious=1 persists; s_done stays 0.
REQ-025 Scenario: areset asserted in ISSUE with outstanding=2 -> next cycle m_req_valid=0 and outstanding=0; with DMA_ISR_ARB_STATS_EN, all grant_cnt slices read 0.

Source files
------------

// File: rtl/dma_isr_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : dma_isr_arbiter
// Description : Round-robin arbiter that funnels per-requester ISR DMA
//               descriptors onto one shared request channel. It tracks issued
//               requests in an in-order ID FIFO and routes each completion
//               pulse back to the requester that owns it.
//               Optional macro DMA_ISR_ARB_STATS_EN adds per-requester
//               32-bit grant counters on output grant_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_isr_arbiter #(
    parameter int N_ID          = 4,
    parameter int REQ_BITS      = 128,
    parameter int N_OUTSTANDING = 8
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [N_ID-1:0]                  s_req_valid,
    output logic [N_ID-1:0]                  s_req_ready,
    input  logic [N_ID*REQ_BITS-1:0]         s_req_data,
    output logic                             m_req_valid,
    input  logic                             m_req_ready,
    output logic [REQ_BITS-1:0]              m_req_data,
    input  logic                             m_done,
    output logic [N_ID-1:0]                  s_done,
    output logic                             err_spurious,
    output logic [$clog2(N_OUTSTANDING):0]   outstanding
`ifdef DMA_ISR_ARB_STATS_EN
    ,
    output logic [N_ID*32-1:0]               grant_cnt
`endif
);

    localparam int c_ID_W  = $clog2(N_ID);
    localparam int c_PTR_W = $clog2(N_OUTSTANDING);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(N_OUTSTANDING);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ISSUE = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_ID_W-1:0]   r_last_grant;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [REQ_BITS-1:0] r_data;
    logic [c_ID_W-1:0]   r_fifo [N_OUTSTANDING];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [N_ID-1:0]     r_s_done;
    logic                r_err;

    logic                w_found;
    logic [c_ID_W-1:0]   w_winner;
    logic [c_ID_W-1:0]   w_idx;
    logic                w_grant;
    logic                w_push;
    logic                w_pop;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= N_ID; i++) begin
            w_idx = c_ID_W'((int'(r_last_grant) + i) % N_ID);
            if (!w_found && s_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Full check uses the registered count only, so a same-cycle pop cannot
    // open a slot for a grant in that cycle.
    assign w_grant = (r_state == c_ST_IDLE) && w_found && (r_count < c_MAX_OUT) && !areset;
    assign w_push  = (r_state == c_ST_ISSUE) && m_req_ready;
    assign w_pop   = m_done && (r_count != '0);

    // One-hot accept to the winner during the grant cycle only
    always_comb begin
        s_req_ready = '0;
        if (w_grant) begin
            s_req_ready[w_winner] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: grant moves to ISSUE, channel handshake returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: if (m_req_ready) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Capture the winner's ID and descriptor at grant; held stable through ISSUE
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_last_grant <= c_ID_W'(N_ID - 1);
            r_grant_id   <= '0;
            r_data       <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
            r_grant_id   <= w_winner;
            r_data       <= s_req_data[int'(w_winner)*REQ_BITS +: REQ_BITS];
        end
    end

    // ID FIFO storage; contents are don't-care while the slot is empty
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_grant_id;
        end
    end

    // FIFO pointers (wrap naturally at the power-of-two depth) and occupancy
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Completion routing to the head owner, plus sticky spurious-done flag
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s_done <= '0;
            r_err    <= 1'b0;
        end else begin
            r_s_done <= '0;
            if (w_pop) begin
                r_s_done[r_fifo[r_rd_ptr]] <= 1'b1;
            end
            if (m_done && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_req_valid  = (r_state == c_ST_ISSUE);
    assign m_req_data   = r_data;
    assign s_done       = r_s_done;
    assign err_spurious = r_err;
    assign outstanding  = r_count;

`ifdef DMA_ISR_ARB_STATS_EN
    for (genvar g = 0; g < N_ID; g++) begin : g_grant_cnt
        logic [31:0] r_cnt;

        // Per-requester wrapping grant counter
        always_ff @(posedge aclk) begin
            if (areset) begin
                r_cnt <= '0;
            end else if (w_grant && (w_winner == c_ID_W'(g))) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign grant_cnt[g*32 +: 32] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_isr_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_dma_isr_arbiter
// Description : Directed self-checking bench for dma_isr_arbiter with the
//               default parameter set (4 requesters, 128-bit descriptors,
//               8 outstanding).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_isr_arbiter;

    localparam int N_ID          = 4;
    localparam int REQ_BITS      = 128;
    localparam int N_OUTSTANDING = 8;

    logic                       aclk;
    logic                       areset;
    logic [N_ID-1:0]            s_req_valid;
    logic [N_ID-1:0]            s_req_ready;
    logic [N_ID*REQ_BITS-1:0]   s_req_data;
    logic                       m_req_valid;
    logic                       m_req_ready;
    logic [REQ_BITS-1:0]        m_req_data;
    logic                       m_done;
    logic [N_ID-1:0]            s_done;
    logic                       err_spurious;
    logic [$clog2(N_OUTSTANDING):0] outstanding;
`ifdef DMA_ISR_ARB_STATS_EN
    logic [N_ID*32-1:0]         grant_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dma_isr_arbiter #(
        .N_ID          (N_ID),
        .REQ_BITS      (REQ_BITS),
        .N_OUTSTANDING (N_OUTSTANDING)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_data   (s_req_data),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_data   (m_req_data),
        .m_done       (m_done),
        .s_done       (s_done),
        .err_spurious (err_spurious),
        .outstanding  (outstanding)
`ifdef DMA_ISR_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Distinct descriptor per requester
    function automatic logic [127:0] desc(input int i);
        return {32'hDEAD_0000 | 32'(i), 32'h0BAD_F00D, 32'(i * 3 + 1), 32'hC0DE_0000 + 32'(i)};
    endfunction

    function automatic logic [127:0] oh(input int i);
        logic [127:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        areset      = 1'b1;
        s_req_valid = '0;
        m_req_ready = 1'b0;
        m_done      = 1'b0;
        for (int i = 0; i < N_ID; i++) s_req_data[i*REQ_BITS +: REQ_BITS] = desc(i);

        // Reset state
        cyc(); cyc(); cyc();
        chk("rst_s_req_ready", 128'(s_req_ready), 0);
        chk("rst_m_req_valid", 128'(m_req_valid), 0);
        chk("rst_m_req_data", m_req_data, 0);
        chk("rst_s_done", 128'(s_done), 0);
        chk("rst_err", 128'(err_spurious), 0);
        chk("rst_outstanding", 128'(outstanding), 0);

        // All requesters valid, channel always ready: order 0,1,2,3,0
        areset      = 1'b0;
        s_req_valid = 4'hF;
        m_req_ready = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk("rr_ready", 128'(s_req_ready), oh(k % 4));
            chk("rr_mvalid_idle", 128'(m_req_valid), 0);
            cyc();
            chk("rr_mvalid_issue", 128'(m_req_valid), 1);
            chk("rr_mdata", m_req_data, desc(k % 4));
            chk("rr_ready_issue", 128'(s_req_ready), 0);
            chk("rr_outstanding", 128'(outstanding), 128'(k));
            cyc();
        end
        s_req_valid = '0;
        m_req_ready = 1'b0;
        settle();
        chk("rr_outstanding_5", 128'(outstanding), 5);

        // Back-to-back completions return in issue order
        m_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("drain_s_done", 128'(s_done), oh(k % 4));
            chk("drain_outstanding", 128'(outstanding), 128'(4 - k));
        end
        m_done = 1'b0;
        cyc();
        chk("drain_s_done_idle", 128'(s_done), 0);
        chk("drain_err", 128'(err_spurious), 0);

        // Requester 2 alone, channel stalled for 5 cycles
        s_req_valid = 4'b0100;
        settle();
        chk("stall_ready", 128'(s_req_ready), oh(2));
        cyc();
        for (int j = 0; j < 5; j++) begin
            chk("stall_mvalid", 128'(m_req_valid), 1);
            chk("stall_mdata", m_req_data, desc(2));
            chk("stall_ready_low", 128'(s_req_ready), 0);
            cyc();
        end
        m_req_ready = 1'b1;
        settle();
        chk("stall_mvalid_end", 128'(m_req_valid), 1);
        cyc();
        s_req_valid = '0;
        settle();
        chk("stall_outstanding", 128'(outstanding), 1);

        // Fill to 8 outstanding: grants 3,0,1,2,3,0,1
        s_req_valid = 4'hF;
        settle();
        for (int k = 0; k < 7; k++) begin
            chk("fill_ready", 128'(s_req_ready), oh((3 + k) % 4));
            cyc();
            cyc();
        end
        chk("full_ready", 128'(s_req_ready), 0);
        chk("full_outstanding", 128'(outstanding), 8);
        cyc();
        chk("full_ready_hold", 128'(s_req_ready), 0);
        chk("full_mvalid", 128'(m_req_valid), 0);
        m_done = 1'b1;
        settle();
        chk("full_no_bypass", 128'(s_req_ready), 0);
        cyc();
        m_done = 1'b0;
        settle();
        chk("full_pop_s_done", 128'(s_done), oh(2));
        chk("full_pop_outstanding", 128'(outstanding), 7);
        chk("full_regrant", 128'(s_req_ready), oh(2));
        cyc();
        chk("full_regrant_data", m_req_data, desc(2));
        cyc();
        s_req_valid = '0;
        settle();
        chk("refill_outstanding", 128'(outstanding), 8);

        // Pop five (3,0,1,2,3) leaving 0,1,2 queued
        m_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("pop5_s_done", 128'(s_done), oh((3 + k) % 4));
            chk("pop5_outstanding", 128'(outstanding), 128'(7 - k));
        end
        m_done = 1'b0;

        // Push and pop in the same cycle at outstanding 3
        s_req_valid = 4'b0001;
        settle();
        chk("pp_ready", 128'(s_req_ready), oh(0));
        cyc();
        m_done = 1'b1;
        settle();
        chk("pp_mvalid", 128'(m_req_valid), 1);
        cyc();
        m_done      = 1'b0;
        s_req_valid = '0;
        settle();
        chk("pp_outstanding", 128'(outstanding), 3);
        chk("pp_s_done_head", 128'(s_done), oh(0));

        // Remaining queue is 1,2,0; then one spurious completion
        m_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("pp_drain_s_done", 128'(s_done), oh((k + 1) % 3));
            chk("pp_drain_outstanding", 128'(outstanding), 128'(2 - k));
        end
        cyc();
        chk("spur_s_done", 128'(s_done), 0);
        chk("spur_err", 128'(err_spurious), 1);
        chk("spur_outstanding", 128'(outstanding), 0);
        m_done = 1'b0;
        cyc();
        chk("spur_err_sticky", 128'(err_spurious), 1);
        chk("spur_s_done_idle", 128'(s_done), 0);

        // Reset while in ISSUE with 2 outstanding
        s_req_valid = 4'hF;
        settle();
        chk("mid_ready_a", 128'(s_req_ready), oh(1));
        cyc(); cyc();
        chk("mid_ready_b", 128'(s_req_ready), oh(2));
        cyc(); cyc();
        chk("mid_ready_c", 128'(s_req_ready), oh(3));
        cyc();
        m_req_ready = 1'b0;
        settle();
        chk("mid_mvalid", 128'(m_req_valid), 1);
        chk("mid_outstanding", 128'(outstanding), 2);
`ifdef DMA_ISR_ARB_STATS_EN
        chk("cnt0", 128'(grant_cnt[31:0]), 5);
        chk("cnt1", 128'(grant_cnt[63:32]), 4);
        chk("cnt2", 128'(grant_cnt[95:64]), 5);
        chk("cnt3", 128'(grant_cnt[127:96]), 4);
`endif
        areset      = 1'b1;
        s_req_valid = '0;
        cyc();
        chk("mid_rst_mvalid", 128'(m_req_valid), 0);
        chk("mid_rst_outstanding", 128'(outstanding), 0);
        chk("mid_rst_mdata", m_req_data, 0);
        chk("mid_rst_err", 128'(err_spurious), 0);
`ifdef DMA_ISR_ARB_STATS_EN
        chk("mid_rst_cnt", 128'(grant_cnt), 0);
`endif
        areset = 1'b0;
        m_done = 1'b1;
        cyc();
        m_done = 1'b0;
        settle();
        chk("post_rst_s_done", 128'(s_done), 0);
        chk("post_rst_err", 128'(err_spurious), 1);
        s_req_valid = 4'hF;
        settle();
        chk("post_rst_ready", 128'(s_req_ready), oh(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
